// File: rtl/softmax_axis_feeder.sv
// softmax_axis_feeder
//   On-chip AXI4-Stream source for softmax_top_16 bring-up. A host write port
//   fills a DEPTH-entry word buffer. A start request then streams the first
//   len_i words as one frame and flags the final beat with m_axis_last_o.
//
// Ports
//   axi_clock_i     : stream and register clock
//   axi_reset_n_i   : asynchronous active-low reset
//   wr_en_i         : buffer write strobe (honoured only outside SEND)
//   wr_addr_i       : buffer write address (addresses >= DEPTH ignored)
//   wr_data_i       : buffer write data
//   start_i         : start-frame request, sampled in IDLE
//   len_i           : frame length, 1..DEPTH
//   busy_o          : high while a frame is in flight
//   done_o          : one-cycle pulse after the final beat is accepted
//   err_o           : one-cycle pulse when a start is rejected for bad length
//   m_axis_valid_o  : stream valid
//   m_axis_data_o   : stream data
//   m_axis_last_o   : final beat of the frame
//   m_axis_ready_i  : downstream ready
//   repeat_i        : (FEEDER_REPEAT_EN only) restart the frame back-to-back
//
// Build option
//   FEEDER_REPEAT_EN : when defined, adds repeat_i. A final beat accepted
//                      while repeat_i is high restarts at buf[0] with no
//                      bubble and no done_o pulse.

module softmax_axis_feeder #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                   axi_clock_i,
  input  logic                   axi_reset_n_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [2*DATA_SIZE-1:0] wr_data_i,
  input  logic                   start_i,
  input  logic [ADDR_W:0]        len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   m_axis_valid_o,
  output logic [2*DATA_SIZE-1:0] m_axis_data_o,
  output logic                   m_axis_last_o,
`ifdef FEEDER_REPEAT_EN
  input  logic                   repeat_i,
`endif
  input  logic                   m_axis_ready_i
);

  localparam int WORD_W = 2 * DATA_SIZE;
  localparam int LEN_W  = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [LEN_W-1:0]   idx_p1;
  logic [LEN_W-1:0]   len_p1;
  logic [LEN_W-1:0]   idx_nxt;
  logic               vld_p1;
  logic [WORD_W-1:0]  data_p1;
  logic               last_p1;
  logic               busy_p1;
  logic               done_p1;
  logic               err_p1;
  logic               wr_ok;
  logic               len_ok;
  logic               final_beat;
  logic               handshake;
  logic               rep;

`ifdef FEEDER_REPEAT_EN
  assign rep = repeat_i;
`else
  assign rep = 1'b0;
`endif

  // Writes are locked out during SEND so the word on the bus cannot change
  // underneath a stalled beat.
  assign wr_ok      = wr_en_i && (state != SEND) && ({1'b0, wr_addr_i} < DEPTH_L);
  assign len_ok     = (len_i != '0) && (len_i <= DEPTH_L);
  assign idx_nxt    = idx_p1 + ONE_L;
  assign final_beat = (idx_p1 == (len_p1 - ONE_L));
  assign handshake  = vld_p1 && m_axis_ready_i;

  // Buffer: deliberately not reset, contents survive a reset.
  always_ff @(posedge axi_clock_i) begin
    if (wr_ok) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Control FSM and registered stream outputs (p1 = output register stage)
  always_ff @(posedge axi_clock_i or negedge axi_reset_n_i) begin
    if (!axi_reset_n_i) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
      idx_p1  <= '0;
      len_p1  <= '0;
    end else begin
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_ok) begin
              len_p1  <= len_i;
              idx_p1  <= '0;
              vld_p1  <= 1'b1;
              data_p1 <= mem[0];
              last_p1 <= (len_i == ONE_L);
              busy_p1 <= 1'b1;
              state   <= SEND;
            end else begin
              err_p1 <= 1'b1;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            if (final_beat) begin
              if (rep) begin
                // Back-to-back restart: valid stays high, same latched length.
                idx_p1  <= '0;
                data_p1 <= mem[0];
                last_p1 <= (len_p1 == ONE_L);
              end else begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
                last_p1 <= 1'b0;
                busy_p1 <= 1'b0;
                done_p1 <= 1'b1;
                state   <= DONE;
              end
            end else begin
              idx_p1  <= idx_nxt;
              data_p1 <= mem[idx_nxt[ADDR_W-1:0]];
              last_p1 <= (idx_nxt == (len_p1 - ONE_L));
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_valid_o = vld_p1;
  assign m_axis_data_o  = data_p1;
  assign m_axis_last_o  = last_p1;
  assign busy_o         = busy_p1;
  assign done_o         = done_p1;
  assign err_o          = err_p1;

endmodule

// File: tb/tb_softmax_axis_feeder.sv
module tb_softmax_axis_feeder;

  localparam int DATA_SIZE = 16;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   wr_en = 1'b0;
  logic [ADDR_W-1:0]      wr_addr = '0;
  logic [2*DATA_SIZE-1:0] wr_data = '0;
  logic                   start = 1'b0;
  logic [ADDR_W:0]        len = '0;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   valid;
  logic [2*DATA_SIZE-1:0] data;
  logic                   last;
  logic                   ready = 1'b1;
`ifdef FEEDER_REPEAT_EN
  logic                   rpt = 1'b0;
`endif

  softmax_axis_feeder #(
    .DATA_SIZE(DATA_SIZE),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .axi_clock_i(clk),
    .axi_reset_n_i(rst_n),
    .wr_en_i(wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .start_i(start),
    .len_i(len),
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .m_axis_valid_o(valid),
    .m_axis_data_o(data),
    .m_axis_last_o(last),
`ifdef FEEDER_REPEAT_EN
    .repeat_i(rpt),
`endif
    .m_axis_ready_i(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int len;
    bit toggle;
    bit poke;
    bit exp_err;
    int exp_beats;
  } vec_t;

  logic [31:0] tb_mem [DEPTH];
  beat_t       exp_q [$];

  int n_chk = 0;
  int n_fail = 0;
  int m_chk = 0;
  int m_fail = 0;
  int hs_cnt = 0;
  int fin_cnt = 0;
  bit mon_en = 1'b0;

  function automatic int cmp(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      return 1;
    end
    return 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    n_fail += cmp(name, act, exp);
  endtask

  // Scoreboard monitor: samples on the falling edge, a beat seen here with
  // valid && ready transfers on the following rising edge.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    beat_t b;
    if (rst_n && mon_en) begin
      m_chk++;
      m_fail += cmp("valid_vs_busy", 32'(valid), 32'(busy));
      if (prev_stall) begin
        m_chk += 3;
        m_fail += cmp("hold_valid", 32'(valid), 32'd1);
        m_fail += cmp("hold_data", data, prev_data);
        m_fail += cmp("hold_last", 32'(last), 32'(prev_last));
      end
      if (valid && ready) begin
        m_chk++;
        if (exp_q.size() == 0) begin
          m_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat at %0t", data, $time);
        end else begin
          b = exp_q.pop_front();
          m_chk++;
          m_fail += cmp("beat_data", data, b.data);
          m_fail += cmp("beat_last", 32'(last), 32'(b.last));
        end
        hs_cnt++;
        if (last) fin_cnt++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_last  = last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_frame(int l);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({tb_mem[i], (i == l - 1)});
    end
  endtask

  // Wait for done_o after the final handshake, toggling ready if asked.
  task automatic wait_done(bit toggle, bit poke, int hs0, int f0, int exp_beats);
    bit got = 1'b0;
    int cyc = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      ready = toggle ? ~ready : 1'b1;
      if (poke && cyc == 2) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF;
      end
      if (poke && cyc == 3) wr_en = 1'b0;
      if (fin_cnt != f0) begin
        chk("done_after_last", 32'(done), 32'd1);
        got = 1'b1;
      end else if (done) begin
        chk("done_early", 32'(done), 32'd0);
      end
    end
    wr_en = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
    chk("end_valid", 32'(valid), 32'd0);
    chk("end_last", 32'(last), 32'd0);
    chk("end_data", data, 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("beat_count", 32'(hs_cnt - hs0), 32'(exp_beats));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    ready = 1'b1;
  endtask

  task automatic run_vec(vec_t v);
    int hs0 = hs_cnt;
    int f0 = fin_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len = (ADDR_W + 1)'(v.len);
    if (!v.exp_err) push_frame(v.len);
    @(posedge clk); #1;
    start = 1'b0;
    ready = v.toggle ? 1'b0 : 1'b1;
    if (v.exp_err) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_valid", 32'(valid), 32'd0);
      chk("err_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("err_one_cycle", 32'(err), 32'd0);
      chk("err_still_idle", 32'(busy), 32'd0);
      chk("err_no_valid", 32'(valid), 32'd0);
      ready = 1'b1;
    end else begin
      chk("start_valid", 32'(valid), 32'd1);
      chk("start_data", data, tb_mem[0]);
      chk("start_last", 32'(last), 32'(v.len == 1));
      chk("start_no_err", 32'(err), 32'd0);
      wait_done(v.toggle, v.poke, hs0, f0, v.exp_beats);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int hs0;
    int f0;
    int cyc;

    tb_mem = '{32'hC053126E, 32'h3E8C49BA, 32'hC0106062, 32'hBFCF3B64,
               32'hC0810E56, 32'hC08547AE, 32'h409849BA, 32'hC09FDF3B,
               32'h3FCBA5E3, 32'hC0873B64, 32'h3F800000, 32'h40000000,
               32'h40400000, 32'h40800000, 32'hBF800000, 32'h00000001};

    //            len toggle poke err beats
    vecs[0] = '{10, 1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{10, 1'b1, 1'b0, 1'b0, 10};
    vecs[2] = '{ 0, 1'b0, 1'b0, 1'b1,  0};
    vecs[3] = '{17, 1'b0, 1'b0, 1'b1,  0};
    vecs[4] = '{ 1, 1'b0, 1'b0, 1'b0,  1};
    vecs[5] = '{10, 1'b0, 1'b1, 1'b0, 10};
    vecs[6] = '{ 1, 1'b1, 1'b0, 1'b0,  1};
    vecs[7] = '{16, 1'b1, 1'b0, 1'b0, 16};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_data = tb_mem[i];
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset after the 4th handshake aborts the frame asynchronously.
    hs0 = hs_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len = 5'd10;
    push_frame(10);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((hs_cnt - hs0) < 4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_test_hs4", 32'(hs_cnt - hs0), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_last", 32'(last), 32'd0);
    chk("abort_data", data, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(valid), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    // Buffer survives reset: a fresh frame replays the stored words.
    run_vec(vecs[0]);

`ifdef FEEDER_REPEAT_EN
    hs0 = hs_cnt;
    f0 = fin_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len = 5'd10;
    rpt = 1'b1;
    push_frame(10);
    push_frame(10);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((hs_cnt - hs0) < 10 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    rpt = 1'b0;
    chk("rep_no_done", 32'(done), 32'd0);
    chk("rep_valid", 32'(valid), 32'd1);
    chk("rep_data", data, 32'hC053126E);
    wait_done(1'b0, 1'b0, hs0, f0 + 1, 20);
`else
    hs0 = 0;
    f0 = 0;
`endif

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    #1;
    n_chk += m_chk;
    n_fail += m_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
